// File: rtl/ysyx_22040632_ifu_pkg.sv
// rtl/ysyx_22040632_ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_22040632_ifu_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef logic [63:0] word_t;
    typedef logic [63:0] vaddr_t;
    typedef logic [31:0] instruction_t;

    // addi x0, x0, 0
    localparam instruction_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_REQ,
        IFU_WAIT,
        IFU_FULL,
        IFU_DRAIN
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040632_ifu.sv
// rtl/ysyx_22040632_ifu.sv - single-outstanding fetch FSM with one-entry decode register
// Optional misaligned-redirect check enabled by YSYX_22040632_IFU_MISALIGN_CHK_EN.
module ysyx_22040632_ifu
    import ysyx_22040632_ifu_pkg::*;
#(
    parameter int unsigned      XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [XLEN-1:0]     id_pc,
    output instruction_t        id_instr,
`ifdef YSYX_22040632_IFU_MISALIGN_CHK_EN
    output logic                id_misalign,
`endif
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
);

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic            kill;

    logic req_fire;
    logic id_fire;
    logic in_flight;

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign id_fire       = id_valid && id_ready;
    assign imem_req_addr = pc;

    // A response is still owed after this cycle unless it arrives right now.
    assign in_flight = req_fire || ((state == IFU_WAIT || kill) && !imem_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IFU_REQ;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            imem_req_valid <= 1'b0;
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_instr       <= '0;
`ifdef YSYX_22040632_IFU_MISALIGN_CHK_EN
            id_misalign    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
`ifdef YSYX_22040632_IFU_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                // Never fetched: present a NOP tagged misaligned. A pending response is drained via kill.
                state          <= IFU_FULL;
                kill           <= in_flight;
                imem_req_valid <= 1'b0;
                id_valid       <= 1'b1;
                id_pc          <= redirect_pc;
                id_instr       <= NOP_INSTR;
                id_misalign    <= 1'b1;
            end else
`endif
            if (in_flight) begin
                state          <= IFU_DRAIN;
                kill           <= 1'b1;
                imem_req_valid <= 1'b0;
            end else begin
                state          <= IFU_REQ;
                kill           <= 1'b0;
                imem_req_valid <= 1'b1;
            end
        end else begin
            if (imem_rsp_valid && kill) begin
                kill <= 1'b0;
            end
            case (state)
                IFU_REQ: begin
                    imem_req_valid <= !req_fire;
                    if (req_fire) begin
                        state <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (imem_rsp_valid && !kill) begin
                        state    <= IFU_FULL;
                        id_valid <= 1'b1;
                        id_pc    <= pc;
                        id_instr <= imem_rsp_data;
                        pc       <= pc + XLEN'(4);
`ifdef YSYX_22040632_IFU_MISALIGN_CHK_EN
                        id_misalign <= (pc[1:0] != 2'b00);
`endif
                    end
                end
                IFU_FULL: begin
                    if (id_fire) begin
                        state          <= IFU_REQ;
                        id_valid       <= 1'b0;
                        imem_req_valid <= 1'b1;
                    end
                end
                IFU_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state          <= IFU_REQ;
                        kill           <= 1'b0;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= IFU_REQ;
                    imem_req_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule
